// File: rtl/seg7_pkg.sv
// Shared constants, the hex font and parameter legality check for the
// seven-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} for a common-anode digit.
  function automatic logic [6:0] seg7_font(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0011000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit seg7_params_ok(input int num_digits, input int div);
    return (num_digits >= 1) && (num_digits <= 8) && (div >= 2);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-register side (load/value/dp_in) and pin side (seg/dp/an) of the
// seven-segment scan driver, bundled for connection.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output load, value, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_hex_font.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_font(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with tear-free frame
// commit. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000
) (
  input  logic               clk,
  input  logic               resetn,
  seg7_scan_driver_if.slave  bus
);

  if (!seg7_params_ok(NUM_DIGITS, DIV)) begin : g_bad_params
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8 and DIV >= 2");
  end

  localparam int PW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]                pcnt_q, pcnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0][3:0]   disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]        disp_dp_q, disp_dp_d;
  logic                         pending_q, pending_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dp_q, dp_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic                         frame_done_q, frame_done_d;

  logic                         tick;
  logic                         commit_tick;
  logic [3:0]                   cur_nib;
  logic [6:0]                   font_seg;
  logic [NUM_DIGITS-1:0]        blank_mask;

  assign tick        = (pcnt_q == PCNT_LAST);
  assign commit_tick = tick && (idx_q == IDX_LAST);

  // Prescaler, digit ring and the shadow/display handover.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    pcnt_d       = tick ? '0 : pcnt_q + PW'(1);
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    if (bus.load) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp_in;
      pending_d    = 1'b1;
    end

    // A load landing on the frame boundary skips the shadow and shows next frame.
    if (commit_tick) begin
      if (bus.load) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
        pending_d  = 1'b0;
      end
    end
  end

`ifdef SEG7_LZB_EN
  // A digit is blank when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    blank_mask  = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zeros_above   = zeros_above && (disp_val_q[k] == 4'h0);
      blank_mask[k] = zeros_above;
    end
  end
`else
  assign blank_mask = '0;
`endif

  assign cur_nib = disp_val_q[idx_q];

  seg7_hex_font u_font (
    .nibble_i (cur_nib),
    .seg_o    (font_seg)
  );

  // Pin outputs, registered from the current scan state.
  always_comb begin
    seg_d        = blank_mask[idx_q] ? SEG_BLANK : font_seg;
    dp_d         = ~disp_dp_q[idx_q];
    an_d         = '1;
    frame_done_d = commit_tick;
    // The first cycle of each slot stays dark so the previous digit cannot ghost.
    if (pcnt_q != '0) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      // NOTE: shadow and display are a handful of flops, not a RAM, so they reset too.
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with NUM_DIGITS = 4, DIV = 4.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int DV = 4;

`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] S_BLK = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_B   = 7'b0000011;
  localparam logic [6:0] S_E   = 7'b0000110;
  localparam logic [6:0] S_F   = 7'b0001110;
  localparam logic [6:0] S_LZ  = LZB ? S_BLK : S_0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic  clk    = 1'b0;
  logic  resetn = 1'b0;
  slot_t sb_q[$];
  int    total  = 0;
  int    bad    = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_if ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .DIV(DV)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected lit pattern of one whole frame, slot 0 first; dp_l is active-low per digit.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dp_l);
    slot_t s;
    logic [6:0] segs [4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    check("sb_empty_before_push", sb_q.size(), 0);
    for (int k = 0; k < ND; k++) begin
      s.an  = ~(4'(1) << k);
      s.seg = segs[k];
      s.dp  = dp_l[k];
      sb_q.push_back(s);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.frame_done && n < 100);
    if (!bus_if.frame_done) check("frame_done_timeout", bus_if.frame_done, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus_if.load  = 1'b1;
    bus_if.value = v;
    bus_if.dp_in = d;
    @(negedge clk);
    bus_if.load  = 1'b0;
  endtask

  // Monitor: the first lit cycle of each slot is the DUT presenting a digit.
  initial begin
    slot_t exp_s;
    logic [3:0] prev_an;
    prev_an = '1;
    forever begin
      @(negedge clk);
      if (bus_if.an != 4'hF && prev_an == 4'hF && sb_q.size() > 0) begin
        exp_s = sb_q.pop_front();
        check("slot_an",  bus_if.an,  exp_s.an);
        check("slot_seg", bus_if.seg, exp_s.seg);
        check("slot_dp",  bus_if.dp,  exp_s.dp);
      end
      prev_an = bus_if.an;
    end
  end

  // frame_done must recur every ND*DV cycles as a single-cycle pulse.
  initial begin
    int gap;
    bit seen;
    gap  = 0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        gap  = 0;
        seen = 1'b0;
      end else begin
        gap++;
        if (bus_if.frame_done) begin
          if (seen) check("frame_period", gap, ND * DV);
          seen = 1'b1;
          gap  = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int m;
    logic [3:0] exp_an;
    bus_if.load  = 1'b0;
    bus_if.value = '0;
    bus_if.dp_in = '0;

    // Reset state.
    @(negedge clk);
    check("rst_seg", bus_if.seg, S_BLK);
    check("rst_dp",  bus_if.dp, 1);
    check("rst_an",  bus_if.an, 4'hF);
    check("rst_fd",  bus_if.frame_done, 0);
    check("rst_pending", dut.pending_q, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Scan pattern after release: one dark cycle then three lit per slot.
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      m      = n - 1;
      exp_an = (m % 4 == 0) ? 4'hF : ~(4'(1) << ((m / 4) % 4));
      check("scan_an", bus_if.an, exp_an);
      check("scan_fd", bus_if.frame_done, (n == 16));
      if (exp_an != 4'hF) begin
        check("scan_seg", bus_if.seg, ((m / 4) % 4 == 0) ? S_0 : S_LZ);
        check("scan_dp",  bus_if.dp, 1);
      end
    end

    // Mid-frame load stays hidden until the frame boundary.
    wait_frame();
    push_frame(S_0, S_LZ, S_LZ, S_LZ, 4'hF);
    repeat (5) @(negedge clk);
    do_load(16'h1A3F, 4'b0100);
    check("pending_after_load", dut.pending_q, 1);
    wait_frame();
    push_frame(S_F, S_3, S_A, S_1, 4'b1011);

    // Two loads in one frame: last write wins.
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'b1111);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'b0001);
    wait_frame();
    push_frame(S_2, S_2, S_2, S_2, 4'b1110);

    // Load on the commit tick bypasses straight into the display.
    repeat (15) @(negedge clk);
    bus_if.load  = 1'b1;
    bus_if.value = 16'hBEEF;
    bus_if.dp_in = 4'b0000;
    wait_frame();
    bus_if.load = 1'b0;
    check("pending_after_bypass", dut.pending_q, 0);
    push_frame(S_F, S_E, S_E, S_B, 4'hF);
    @(negedge clk);
    check("bypass_seg", bus_if.seg, S_F);
    check("bypass_blank_an", bus_if.an, 4'hF);

    // Leading zeros.
    repeat (3) @(negedge clk);
    do_load(16'h0050, 4'b0000);
    wait_frame();
    push_frame(S_0, S_5, S_LZ, S_LZ, 4'hF);
    wait_frame();
    push_frame(S_0, S_5, S_LZ, S_LZ, 4'hF);

    // Asynchronous reset in slot 2 with a load pending.
    repeat (2) @(negedge clk);
    do_load(16'h9876, 4'hF);
    repeat (8) @(negedge clk);
    check("pre_rst_idx", dut.idx_q, 2);
    check("pre_rst_pending", dut.pending_q, 1);
    resetn = 1'b0;
    #1;
    check("arst_seg", bus_if.seg, S_BLK);
    check("arst_an",  bus_if.an, 4'hF);
    check("arst_dp",  bus_if.dp, 1);
    check("arst_pending", dut.pending_q, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_frame();
    push_frame(S_0, S_LZ, S_LZ, S_LZ, 4'hF);
    wait_frame();
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
